// File: rtl/cpu_pkg.sv
// Shared types and defaults for the CPU memory-side blocks.
package cpu_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  // Requester identity; GNT_IF is also the reset value of last-grant.
  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } arb_gnt_t;

  // Granted access as remembered for the duration of the access.
  typedef struct packed {
    arb_gnt_t id;
    logic     we;
  } arb_req_t;

  // Wait counter width: must hold LAT-1, never narrower than one bit.
  function automatic int cnt_w(input int lat);
    return (lat <= 2) ? 1 : $clog2(lat);
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-requester round-robin pick: on a tie the requester not served last wins.
module rr_pick2
  import cpu_pkg::*;
(
  input  logic     req_if,
  input  logic     req_d,
  input  arb_gnt_t last_gnt,
  output logic     gnt_vld,
  output arb_gnt_t gnt_id
);

  // Single request wins outright; a tie flips away from last_gnt.
  always_comb begin
    gnt_vld = req_if | req_d;
    gnt_id  = GNT_IF;
    if (req_if && req_d)
      gnt_id = (last_gnt == GNT_IF) ? GNT_D : GNT_IF;
    else if (req_d)
      gnt_id = GNT_D;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of a single-ported fixed-latency memory.
// Each access walks IDLE -> ISSUE -> WAIT -> DONE; every output is registered.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  // fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic              if_rdy,
  output logic [DATA_W-1:0] if_rdata,
  // data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_rdy,
  output logic [DATA_W-1:0] d_rdata,
  // memory side
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = cnt_w(LAT);

  arb_state_t        state, state_nxt;
  arb_req_t          req_q;
  arb_gnt_t          last_gnt;
  logic              kill_q;
  logic [CNT_W-1:0]  cnt;

  logic              pick_vld;
  arb_gnt_t          pick_id;
  logic              gnt_we;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_wdata;
  logic              grant;
  logic              kill_now;
  logic              wait_end;
  logic              if_dead;

  rr_pick2 u_pick (
    .req_if   (if_req),
    .req_d    (d_req),
    .last_gnt (last_gnt),
    .gnt_vld  (pick_vld),
    .gnt_id   (pick_id)
  );

  // Winner's access fields, selected once and shared by the latches below.
  always_comb begin
    gnt_we    = (pick_id == GNT_D) && d_we;
    gnt_addr  = (pick_id == GNT_D) ? d_addr : if_addr;
    gnt_wdata = (pick_id == GNT_D) ? d_wdata : '0;
  end

  // Event decode: grant taken, kill seen this cycle, last WAIT cycle.
  always_comb begin
    grant    = (state == IDLE) && pick_vld;
    kill_now = if_kill && (state != IDLE) && (req_q.id == GNT_IF);
    wait_end = (state == WAIT) && (cnt == '0);
    if_dead  = kill_q || kill_now;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: DONE always returns to IDLE so a still-held request is not re-granted.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Access bookkeeping: who is granted, wait countdown, fairness and kill flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q    <= '{id: GNT_IF, we: 1'b0};
      last_gnt <= GNT_IF;
      kill_q   <= 1'b0;
      cnt      <= '0;
    end else begin
      if (grant)
        req_q <= '{id: pick_id, we: gnt_we};
      if (state == ISSUE)
        cnt <= CNT_W'(LAT - 1);
      else if (state == WAIT && cnt != '0)
        cnt <= cnt - 1'b1;
      if (state == DONE)
        last_gnt <= req_q.id;
      // kill only matters while the fetch owns the access; IDLE forgets it
      if (state == IDLE)
        kill_q <= 1'b0;
      else if (kill_now)
        kill_q <= 1'b1;
    end
  end

  // Registered memory strobe and fields; addr/wdata hold between accesses.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= grant;
      mem_we <= grant && gnt_we;
      if (grant) begin
        mem_addr  <= gnt_addr;
        mem_wdata <= gnt_wdata;
      end
    end
  end

  // Read capture on the last WAIT cycle and rdy pulses landing in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_rdy   <= 1'b0;
      d_rdy    <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      if_rdy <= wait_end && (req_q.id == GNT_IF) && !if_dead;
      d_rdy  <= wait_end && (req_q.id == GNT_D);
      if (wait_end && (req_q.id == GNT_IF) && !if_dead)
        if_rdata <= mem_rdata;
      if (wait_end && (req_q.id == GNT_D) && !req_q.we)
        d_rdata <= mem_rdata;
    end
  end

  // busy mirrors state != IDLE, registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) busy <= 1'b0;
    else     busy <= (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a LAT=2 instance for directed cases, a LAT=1
// instance for a randomized sweep against a cycle-level reference model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // LAT=2 instance
  logic        if_req, if_kill, if_rdy, d_req, d_we, d_rdy;
  logic [15:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic        mem_en, mem_we, busy;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  // LAT=1 instance
  logic        if_req1, if_kill1, if_rdy1, d_req1, d_we1, d_rdy1;
  logic [15:0] if_addr1, if_rdata1, d_addr1, d_wdata1, d_rdata1;
  logic        mem_en1, mem_we1, busy1;
  logic [15:0] mem_addr1, mem_wdata1, mem_rdata1;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .LAT(2)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill), .if_rdy(if_rdy), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdy(d_rdy), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req1), .if_addr(if_addr1), .if_kill(if_kill1), .if_rdy(if_rdy1), .if_rdata(if_rdata1),
    .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1), .d_rdy(d_rdy1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .busy(busy1)
  );

  // Untouched memory locations read as a fixed function of address.
  function automatic logic [15:0] init_val(input logic [15:0] a);
    return 16'hBEEF ^ (a - 16'h0040);
  endfunction

  // Memory models: write in the mem_en cycle, read data LAT cycles later.
  logic [15:0] mem_a [0:255];
  bit          mem_a_wr [0:255];
  logic [15:0] rd_a1, rd_a2;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem_a[mem_addr[7:0]]    <= mem_wdata;
        mem_a_wr[mem_addr[7:0]] <= 1'b1;
      end
      rd_a1 <= mem_a_wr[mem_addr[7:0]] ? mem_a[mem_addr[7:0]] : init_val(mem_addr);
    end
    rd_a2 <= rd_a1;
  end
  assign mem_rdata = rd_a2;

  logic [15:0] mem_b [0:255];
  bit          mem_b_wr [0:255];
  logic [15:0] rd_b1;
  always @(posedge clk) begin
    if (mem_en1) begin
      if (mem_we1) begin
        mem_b[mem_addr1[7:0]]    <= mem_wdata1;
        mem_b_wr[mem_addr1[7:0]] <= 1'b1;
      end
      rd_b1 <= mem_b_wr[mem_addr1[7:0]] ? mem_b[mem_addr1[7:0]] : init_val(mem_addr1);
    end
  end
  assign mem_rdata1 = rd_b1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Table for the both-from-reset case: exp = {mem_en, mem_we, if_rdy, d_rdy, busy}
  typedef struct {
    logic        ir;
    logic        dr;
    logic [4:0]  exp;
    logic [15:0] addr;
  } vec_t;
  vec_t tv [0:10];

  // Request-level shadow of memory for the sweep.
  logic [15:0] shadow [int];
  function automatic logic [15:0] rd_sh(input logic [15:0] a);
    return shadow.exists(int'(a)) ? shadow[int'(a)] : init_val(a);
  endfunction

  logic [15:0] gq [$];

  initial begin
    tv[0]  = '{1'b1, 1'b1, 5'b00000, 16'h0000};
    tv[1]  = '{1'b1, 1'b1, 5'b11001, 16'h0010};
    tv[2]  = '{1'b1, 1'b1, 5'b00001, 16'h0000};
    tv[3]  = '{1'b1, 1'b1, 5'b00001, 16'h0000};
    tv[4]  = '{1'b1, 1'b1, 5'b00011, 16'h0000};
    tv[5]  = '{1'b1, 1'b0, 5'b00000, 16'h0000};
    tv[6]  = '{1'b1, 1'b0, 5'b10001, 16'h0000};
    tv[7]  = '{1'b1, 1'b0, 5'b00001, 16'h0000};
    tv[8]  = '{1'b1, 1'b0, 5'b00001, 16'h0000};
    tv[9]  = '{1'b1, 1'b0, 5'b00101, 16'h0000};
    tv[10] = '{1'b0, 1'b0, 5'b00000, 16'h0000};

    rst = 1'b1;
    if_req = 0; if_kill = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    if_req1 = 0; if_kill1 = 0; if_addr1 = 0; d_req1 = 0; d_we1 = 0; d_addr1 = 0; d_wdata1 = 0;

    // reset state, requests already present while rst is high
    repeat (3) begin tick(); if_req = 1; d_req = 1; smp(); end
    chk("rst_busy",    32'(busy), 0);
    chk("rst_mem",     32'({mem_en, mem_we}), 0);
    chk("rst_rdy",     32'({if_rdy, d_rdy}), 0);
    chk("rst_addr",    32'(mem_addr), 0);
    chk("rst_wdata",   32'(mem_wdata), 0);
    chk("rst_rdata",   {if_rdata, d_rdata}, 0);
    chk("rst_busy1",   32'({busy1, mem_en1}), 0);

    // both requests from reset: store wins the first tie, fetch follows
    d_we = 1; d_addr = 16'h0010; d_wdata = 16'h1234; if_addr = 16'h0000;
    for (int i = 0; i <= 10; i++) begin
      tick();
      rst = 1'b0;
      if_req = tv[i].ir;
      d_req  = tv[i].dr;
      smp();
      chk($sformatf("t2_cyc%0d", i), 32'({mem_en, mem_we, if_rdy, d_rdy, busy}), 32'(tv[i].exp));
      if (tv[i].exp[4]) chk($sformatf("t2_addr%0d", i), 32'(mem_addr), 32'(tv[i].addr));
      if (tv[i].exp[3]) chk("t2_wdata", 32'(mem_wdata), 32'h1234);
      if (i == 4) chk("t2_store_rdata", 32'(d_rdata), 0);
      if (i == 9) chk("t2_if_rdata", 32'(if_rdata), 32'(init_val(16'h0000)));
    end
    chk("t2_mem_written", 32'(mem_a[8'h10]), 32'h1234);

    // single load, LAT=2 timing
    for (int c = 0; c <= 5; c++) begin
      tick();
      d_req = (c <= 4); d_we = 0; d_addr = 16'h0040;
      smp();
      chk($sformatf("t1_mem_en%0d", c), 32'(mem_en), 32'(c == 1));
      if (c == 1) chk("t1_addr", 32'(mem_addr), 32'h0040);
      chk($sformatf("t1_d_rdy%0d", c), 32'(d_rdy), 32'(c == 4));
      if (c == 4) chk("t1_d_rdata", 32'(d_rdata), 32'hBEEF);
      chk($sformatf("t1_busy%0d", c), 32'(busy), 32'(c >= 1 && c <= 4));
    end

    // fetch killed in WAIT: access completes, no rdy, rdata kept
    for (int c = 0; c <= 6; c++) begin
      tick();
      if_req = (c <= 2); if_addr = 16'h0050; if_kill = (c == 2);
      smp();
      chk($sformatf("k_if_rdy%0d", c), 32'(if_rdy), 0);
      chk($sformatf("k_mem_en%0d", c), 32'(mem_en), 32'(c == 1));
      chk($sformatf("k_busy%0d", c), 32'(busy), 32'(c >= 1 && c <= 4));
    end
    chk("k_if_rdata", 32'(if_rdata), 32'(init_val(16'h0000)));

    // both held: grants alternate D, IF, D, IF
    if_addr = 16'h0100; d_addr = 16'h0200; d_we = 0;
    for (int c = 0; c <= 21; c++) begin
      tick();
      if_req = (c <= 19); d_req = (c <= 14);
      smp();
      if (mem_en) gq.push_back(mem_addr);
    end
    chk("rr_count", 32'(gq.size()), 4);
    for (int i = 0; i < 4 && i < gq.size(); i++)
      chk($sformatf("rr_gnt%0d", i), 32'(gq[i]), (i % 2 == 0) ? 32'h0200 : 32'h0100);

    // reset in WAIT: access dropped, held request re-issues after reset
    for (int c = 0; c <= 8; c++) begin
      tick();
      rst = (c == 2); d_req = (c <= 7); d_we = 0; d_addr = 16'h0044;
      smp();
      chk($sformatf("r_d_rdy%0d", c), 32'(d_rdy), 32'(c == 7));
      chk($sformatf("r_mem_en%0d", c), 32'(mem_en), 32'(c == 1 || c == 4));
      chk($sformatf("r_busy%0d", c), 32'(busy), 32'((c >= 1 && c <= 2) || (c >= 4 && c <= 7)));
      if (c == 3) chk("r_d_rdata_rst", 32'(d_rdata), 0);
      if (c == 7) chk("r_d_rdata", 32'(d_rdata), 32'(init_val(16'h0044)));
    end

    // LAT=1 random sweep against a cycle-level model of the arbiter
    begin
      int cyc = 0, free_at = 0, rdy_at = -1, gnt_at = -10, done_cnt = 0, issued = 0, gsel = 0;
      bit pend_if = 0, pend_d = 0, last_d = 0, exp_ld = 0;
      logic [15:0] exp_data = '0;
      while (done_cnt < 100 && cyc < 4000) begin
        tick();
        if (!pend_if && issued < 100 && $urandom_range(0, 2) == 0) begin
          pend_if = 1; if_addr1 = 16'($urandom_range(0, 15)); issued++;
        end
        if (!pend_d && issued < 100 && $urandom_range(0, 2) == 0) begin
          pend_d = 1; d_addr1 = 16'($urandom_range(0, 15));
          d_we1 = 1'($urandom_range(0, 1)); d_wdata1 = 16'($urandom); issued++;
        end
        if_req1 = pend_if; d_req1 = pend_d;
        if (cyc >= free_at && (pend_if || pend_d)) begin
          gsel   = (pend_if && pend_d) ? (last_d ? 0 : 1) : (pend_d ? 1 : 0);
          last_d = (gsel == 1);
          gnt_at = cyc; rdy_at = cyc + 3; free_at = cyc + 4;
          if (gsel == 0) begin
            exp_ld = 1; exp_data = rd_sh(if_addr1);
          end else if (d_we1) begin
            exp_ld = 0; shadow[int'(d_addr1)] = d_wdata1;
          end else begin
            exp_ld = 1; exp_data = rd_sh(d_addr1);
          end
        end
        smp();
        chk("sw_mem_en", 32'(mem_en1), 32'(cyc == gnt_at + 1));
        chk("sw_if_rdy", 32'(if_rdy1), 32'(cyc == rdy_at && gsel == 0));
        chk("sw_d_rdy",  32'(d_rdy1),  32'(cyc == rdy_at && gsel == 1));
        if (cyc == rdy_at) begin
          if (exp_ld)
            chk(gsel == 0 ? "sw_if_data" : "sw_d_data",
                32'(gsel == 0 ? if_rdata1 : d_rdata1), 32'(exp_data));
          if (gsel == 0) pend_if = 0; else pend_d = 0;
          done_cnt++;
        end
        cyc++;
      end
      chk("sw_completed", 32'(done_cnt), 100);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one single-ported, fixed-latency unified memory between the CPU fetch port and the MEM-stage data port. It sits between the pipeline and the memory. It sequences each access through a registered issue/wait/complete state machine and returns one-cycle ready pulses, which the pipeline uses to stall IF and MEM. Conflicting requests are resolved round-robin.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- LAT, 2, memory read latency in cycles from the mem_en cycle to valid mem_rdata; must be ≥1
- clk  in  1  clock
- rst  in  1  reset; synchronous and active-high
- if_req  in  1  fetch request; held until if_rdy or if_kill
- if_addr  in  ADDR_W  fetch address; stable while if_req
- if_kill  in  1  abandon the in-flight fetch (branch redirect)
- if_rdy  out  1  one-cycle pulse: fetch complete
- if_rdata  out  DATA_W  fetched instruction; valid with if_rdy
- d_req  in  1  data request; held until d_rdy
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdy  out  1  one-cycle pulse: data access complete
- d_rdata  out  DATA_W  load data; valid with d_rdy
- mem_en  out  1  memory access strobe, one cycle per access
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid LAT cycles after mem_en
- busy  out  1  state ≠ IDLE

## Operation
- States are IDLE, ISSUE, WAIT and DONE.
- IDLE:
  - No request: stay.
  - Exactly one request: grant it.
  - Both requests: grant the requester not served last. The last-grant register resets to IF, so the first tie goes to data.
  - On grant: latch requester id, addr, we, wdata → ISSUE.
- ISSUE: mem_en=1 for exactly this cycle, with mem_we/addr/wdata from the latch; load wait counter with LAT-1 → WAIT.
- WAIT: decrement each cycle. At count 0, capture mem_rdata into the granted port's rdata register (loads and fetches only) → DONE.
- DONE:
  - Pulse the granted port's rdy.
  - Update the last-grant register.
  - Ignore requests → IDLE.
  - The DONE cycle prevents re-granting a request the requester is still holding in the rdy cycle.
- Stores: the memory is written in the ISSUE cycle; d_rdy still pulses in DONE; d_rdata is unchanged.
- if_kill:
  - Sampled in ISSUE, WAIT or DONE while IF is granted.
  - Sets a kill flag. The access still runs to completion on the memory side.
  - if_rdy is suppressed and if_rdata is not updated.
  - The kill flag clears in IDLE.
  - if_kill in IDLE, or while data is granted, has no effect.
- Requester rules: dropping req without rdy (or kill, for IF) is illegal and the behaviour is unspecified. The bench checks that this does not occur.
- if_rdata and d_rdata hold their last captured value between pulses.

## Timing
- Request sampled in IDLE in cycle t:
  - mem_en in cycle t+1.
  - Capture at the end of cycle t+1+LAT.
  - rdy in cycle t+2+LAT.
  - IDLE again at t+3+LAT.
- Throughput: one access per LAT+3 cycles. The losing requester waits one full access.
- Reset values: state=IDLE, last-grant=IF, kill=0. mem_en, mem_we, if_rdy, d_rdy and busy are 0. mem_addr, mem_wdata, if_rdata and d_rdata are 0.
- rst asserted in any state: IDLE on the next edge and mem_en=0 on the next cycle. The in-flight access is discarded with no rdy pulse, and the memory may already hold the store.
- rst and a request together: reset wins; the request is considered from the first IDLE cycle after reset deasserts.
- All outputs are registered; there is no combinational path from req to mem_* or rdy.

## Structure
- Shared package cpu_pkg holds:
  - arb_state_t (IDLE, ISSUE, WAIT, DONE)
  - arb_gnt_t (GNT_IF, GNT_D)
  - ADDR_W/DATA_W defaults
- Sub-module rr_pick2: two-requester round-robin pick. Inputs are the two requests and last-grant; outputs are grant valid and grant id. It is combinational and lives beside the FSM.
- Counter width: $clog2(LAT) with a minimum of 1.

## Test plan
- LAT=2; d_req load addr 0x0040 at cycle 0, memory returns 0xBEEF → mem_en/mem_addr=0x0040 in cycle 1, d_rdy=1 and d_rdata=0xBEEF in cycle 4, busy low in cycle 5.
- if_req 0x0000 and d_req store 0x0010←0x1234, both arriving at cycle 0 from reset:
  - store issued first (mem_we=1 in cycle 1), d_rdy in cycle 4;
  - fetch mem_en in cycle 6, if_rdy in cycle 9.
- Both requests held continuously for 4 accesses → grants alternate D, IF, D, IF; no port is served twice in a row.
- Fetch granted; if_kill pulsed in cycle 2 (WAIT) → the mem access completes, no if_rdy pulse, if_rdata unchanged, IDLE at cycle 5.
- rst asserted in WAIT → busy=0 and mem_en=0 the next cycle, no rdy pulse; a held d_req re-issues from IDLE after rst deasserts.
- LAT=1 sweep of 100 random requests against a memory model → every rdy carries model data, with exactly LAT+2 cycles from grant to rdy.
